// File: rtl/jtkiwi_rom_arb.sv
// jtkiwi_rom_arb
// Arbitrates two ROM requesters onto one memory port. The two requesters are
// the tilemap draw engine (0) and the sprite draw engine (1). Each requester
// has a one-entry cache (tag/data/valid). A hit is reported combinationally.
// A miss starts one memory transaction. When both requesters miss, the one
// that was not served last is granted.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   i_inv                 one-cycle pulse, invalidates both caches
//   i_req_cs[1:0]         per-requester chip select
//   i_req_addr0/1         per-requester word address (AW bits)
//   o_req_ok[1:0]         per-requester data valid (combinational hit)
//   o_req_data0/1         per-requester cached data
//   o_mem_cs, o_mem_addr  memory request and address
//   i_mem_ok, i_mem_data  memory data valid and data
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; arbitrate misses, latch grant and address
// SERVE   | o_mem_cs high, waiting for i_mem_ok; fill cache on i_mem_ok
// RELEASE | one cycle of o_mem_cs low before arbitrating again
module jtkiwi_rom_arb #(
    parameter int AW = 18,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_inv,
    input  logic [1:0]    i_req_cs,
    input  logic [AW-1:0] i_req_addr0,
    input  logic [AW-1:0] i_req_addr1,
    output logic [1:0]    o_req_ok,
    output logic [DW-1:0] o_req_data0,
    output logic [DW-1:0] o_req_data1,
    output logic          o_mem_cs,
    output logic [AW-1:0] o_mem_addr,
    input  logic          i_mem_ok,
    input  logic [DW-1:0] i_mem_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_tag0;
    logic [AW-1:0] r_tag1;
    logic [DW-1:0] r_data0;
    logic [DW-1:0] r_data1;
    logic [1:0]    r_valid;
    logic          r_ptr;       // requester granted most recently
    logic          r_gnt;       // requester owning the current transaction
    logic [AW-1:0] r_mem_addr;

    logic [1:0]    w_hit;
    logic [1:0]    w_miss;
    logic          w_gnt_nxt;
    logic          w_start;
    logic          w_fill;

    assign w_hit[0] = i_req_cs[0] & r_valid[0] & (i_req_addr0 == r_tag0);
    assign w_hit[1] = i_req_cs[1] & r_valid[1] & (i_req_addr1 == r_tag1);
    assign w_miss   = i_req_cs & ~w_hit;

    // On a tie the requester not served last wins; otherwise the sole misser.
    always_comb begin
        w_gnt_nxt = 1'b0;
        if (w_miss == 2'b11) begin
            w_gnt_nxt = ~r_ptr;
        end else begin
            w_gnt_nxt = w_miss[1];
        end
    end

    assign w_start = (r_state == ST_IDLE) && (w_miss != 2'b00);
    assign w_fill  = (r_state == ST_SERVE) && i_mem_ok;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_start) w_state_nxt = ST_SERVE;
            ST_SERVE:   if (i_mem_ok) w_state_nxt = ST_RELEASE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs. o_mem_cs decodes the state so async reset drops it at once.
    always_comb begin
        o_mem_cs    = (r_state == ST_SERVE);
        o_mem_addr  = r_mem_addr;
        o_req_ok    = w_hit;
        o_req_data0 = r_data0;
        o_req_data1 = r_data1;
    end

    // Grant/address latch and cache fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= 1'b0;
            r_ptr      <= 1'b1;
            r_mem_addr <= '0;
            r_tag0     <= '0;
            r_tag1     <= '0;
            r_data0    <= '0;
            r_data1    <= '0;
            r_valid    <= 2'b00;
        end else begin
            if (w_start) begin
                r_gnt      <= w_gnt_nxt;
                r_mem_addr <= w_gnt_nxt ? i_req_addr1 : i_req_addr0;
            end
            // The fill uses the latched address, whatever the requester shows now.
            if (w_fill) begin
                r_ptr <= r_gnt;
                if (r_gnt) begin
                    r_tag1  <= r_mem_addr;
                    r_data1 <= i_mem_data;
                end else begin
                    r_tag0  <= r_mem_addr;
                    r_data0 <= i_mem_data;
                end
            end
            // Invalidate wins over a fill on the same edge.
            if (i_inv) begin
                r_valid <= 2'b00;
            end else if (w_fill) begin
                r_valid[r_gnt] <= 1'b1;
            end
        end
    end

endmodule
